// File: rtl/tt_mm_host_pkg.sv
// ---------------------------------------------------------------------------
// tt_mm_host_pkg
// Shared definitions for the Tiny Tapeout 2x2 matrix-multiplier host driver:
// sequencer state encoding, uio pin indices, the fixed uio output-enable mask,
// transfer sizes and a byte-select helper.
// ---------------------------------------------------------------------------
package tt_mm_host_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD_SETUP  = 3'd1,
    LOAD_STROBE = 3'd2,
    WAIT_DONE   = 3'd3,
    READ        = 3'd4,
    READ_GAP    = 3'd5,
    COMPLETE    = 3'd6,
    ERR         = 3'd7
  } state_e;

  // uio pin roles as seen from the host
  localparam int UIO_WR_STB = 0;
  localparam int UIO_DONE   = 1;
  localparam int UIO_RD_STB = 2;

  // The host only ever drives the two strobe pins
  localparam logic [7:0] UIO_OE_MASK = 8'h05;

  localparam int N_OPERAND_BYTES = 8;
  localparam int N_RESULT_BYTES  = 8;

  // Select byte 'sel' of a 64-bit word, byte 0 being the least significant
  function automatic logic [7:0] pick_byte(input logic [63:0] word, input logic [2:0] sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/tt_mm_host_driver_if.sv
// ---------------------------------------------------------------------------
// tt_mm_host_driver_if
// Pin bundle between the FPGA host sequencer and the Tiny Tapeout project.
//   tt_ui_in   : operand byte lane          (host -> DUT)
//   tt_uo_out  : result byte lane           (DUT  -> host)
//   tt_uio_in  : uio pins as seen by host   (bit1 = DUT done)
//   tt_uio_out : host-driven uio values     (bit0 = wr_stb, bit2 = rd_stb)
//   tt_uio_oe  : host uio output enables    (constant 8'h05)
// Modports: master = host side, slave = DUT / pin-wrapper side.
// ---------------------------------------------------------------------------
interface tt_mm_host_driver_if;

  logic [7:0] tt_ui_in;
  logic [7:0] tt_uo_out;
  logic [7:0] tt_uio_in;
  logic [7:0] tt_uio_out;
  logic [7:0] tt_uio_oe;

  modport master (
    output tt_ui_in,
    output tt_uio_out,
    output tt_uio_oe,
    input  tt_uo_out,
    input  tt_uio_in
  );

  modport slave (
    input  tt_ui_in,
    input  tt_uio_out,
    input  tt_uio_oe,
    output tt_uo_out,
    output tt_uio_in
  );

endinterface

// File: rtl/tt_pin_sync2.sv
// ---------------------------------------------------------------------------
// tt_pin_sync2
// Parameterised-width two-flop synchronizer for pins arriving from an
// off-FPGA Tiny Tapeout board. Only built when TT_MMH_SYNC2_EN is defined,
// which is the only configuration that instantiates it.
// Ports:
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears both stages
//   d_i  : asynchronous input bits
//   q_o  : synchronized bits, two cycles behind d_i
// ---------------------------------------------------------------------------
`ifdef TT_MMH_SYNC2_EN
module tt_pin_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`endif

// File: rtl/tt_mm_host_driver.sv
// ---------------------------------------------------------------------------
// tt_mm_host_driver
// Host-side sequencer for the 2x2 matrix-multiplier Tiny Tapeout project.
// Sends eight operand bytes (a00,a01,a10,a11,b00,b01,b10,b11) on ui_in with a
// write strobe each, waits for the DUT done flag (with timeout), then reads
// eight result bytes (c00 lo .. c11 hi) from uo_out with a read strobe each.
//
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in WAIT_DONE before flagging an error
//   SETUP_CYCLES   : cycles each operand byte is held before its strobe (>=1)
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : one-cycle run request, sampled only in IDLE
//   a_mat/b_mat: operands {x11,x10,x01,x00}, 8-bit unsigned elements
//   busy       : transaction in flight (cycle after start .. before done)
//   done       : one-cycle end-of-transaction pulse (success or error)
//   error      : sticky timeout flag, cleared by the next accepted start
//   result     : {c11,c10,c01,c00}, 16 bits each, held until the next start
//   pins       : TT pin bundle (master side)
//
// Build option:
//   TT_MMH_SYNC2_EN : pass uo_out/uio_in through 2-flop synchronizers; done
//                     is seen 2 cycles later and each read byte takes 4 cycles.
// ---------------------------------------------------------------------------
module tt_mm_host_driver
  import tt_mm_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SETUP_CYCLES   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                a_mat,
  input  logic [31:0]                b_mat,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [63:0]                result,
  tt_mm_host_driver_if.master        pins
);

  // One shared counter covers setup hold, timeout and read gap
  localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + SETUP_CYCLES + 4);
  localparam logic [2:0] LAST_OP  = 3'(N_OPERAND_BYTES - 1);
  localparam logic [2:0] LAST_RES = 3'(N_RESULT_BYTES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q;
  logic [2:0]       rdx_q;
  logic [63:0]      ops_q;
  logic [7:0]       tt_ui_in_q;
  logic             error_q;
  logic [7:0]       res_q [N_RESULT_BYTES];

  logic [7:0]       uo_out_s;
  logic [7:0]       uio_in_s;
  logic             dut_done;
  logic             sample_en;
  logic             start_acc;
  logic             wr_stb;
  logic             rd_stb;
  logic [7:0]       uio_out_c;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
`ifdef TT_MMH_SYNC2_EN
  // Read gap: 1 idle cycle plus 2 cycles of synchronizer latency
  localparam int GAP_CYCLES = 3;

  logic [15:0] pins_sync;

  tt_pin_sync2 #(.WIDTH(16)) u_pin_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({pins.tt_uio_in, pins.tt_uo_out}),
    .q_o (pins_sync)
  );

  assign uio_in_s = pins_sync[15:8];
  assign uo_out_s = pins_sync[7:0];
  // The byte presented before the strobe edge reaches the second flop two
  // edges later; the DUT pointer has already moved, so sample exactly then.
  assign sample_en = (state_q == READ_GAP) && (cnt_q == CNT_W'(1));
`else
  localparam int GAP_CYCLES = 1;

  assign uio_in_s  = pins.tt_uio_in;
  assign uo_out_s  = pins.tt_uo_out;
  // Sampled on the same edge that advances the DUT read pointer
  assign sample_en = (state_q == READ);
`endif

  assign dut_done  = uio_in_s[UIO_DONE];
  assign start_acc = (state_q == IDLE) && start;

  logic unused_uio_bits;
  assign unused_uio_bits = ^{uio_in_s[7:2], uio_in_s[0]};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_SETUP;
      end
      LOAD_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) state_d = LOAD_STROBE;
      end
      LOAD_STROBE: begin
        state_d = (idx_q == LAST_OP) ? WAIT_DONE : LOAD_SETUP;
      end
      WAIT_DONE: begin
        // done has priority over a coincident timeout
        if (dut_done) begin
          state_d = READ;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
        end
      end
      READ: begin
        state_d = READ_GAP;
      end
      READ_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = (rdx_q == LAST_RES) ? COMPLETE : READ;
        end
      end
      COMPLETE: state_d = IDLE;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (decoded from the registered state, so glitch-free per cycle)
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    wr_stb    = 1'b0;
    rd_stb    = 1'b0;
    uio_out_c = 8'h00;
    case (state_q)
      LOAD_SETUP, WAIT_DONE, READ_GAP: busy = 1'b1;
      LOAD_STROBE: begin
        busy   = 1'b1;
        wr_stb = 1'b1;
      end
      READ: begin
        busy   = 1'b1;
        rd_stb = 1'b1;
      end
      COMPLETE, ERR: done = 1'b1;
      default: ;
    endcase
    uio_out_c[UIO_WR_STB] = wr_stb;
    uio_out_c[UIO_RD_STB] = rd_stb;
  end

  // The counter restarts on every state change and rests at zero in IDLE
  always_comb begin
    if ((state_d != state_q) || (state_q == IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      rdx_q      <= '0;
      ops_q      <= '0;
      tt_ui_in_q <= '0;
      error_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (start_acc) begin
        ops_q      <= {b_mat, a_mat};
        idx_q      <= '0;
        rdx_q      <= '0;
        tt_ui_in_q <= a_mat[7:0];
        error_q    <= 1'b0;
      end
      // Next operand is put on the lane as the strobe drops, so it is held
      // for the whole setup window before its own strobe.
      if ((state_q == LOAD_STROBE) && (state_d == LOAD_SETUP)) begin
        idx_q      <= idx_q + 3'd1;
        tt_ui_in_q <= pick_byte(ops_q, idx_q + 3'd1);
      end
      if ((state_q == READ_GAP) && (state_d != READ_GAP)) begin
        rdx_q <= rdx_q + 3'd1;
      end
      if (state_d == ERR) begin
        error_q <= 1'b1;
      end
    end
  end

  // Result bytes: one register per byte, written when its slot is sampled
  genvar gi;
  generate
    for (gi = 0; gi < N_RESULT_BYTES; gi++) begin : g_res
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_q[gi] <= '0;
        end else if (start_acc) begin
          res_q[gi] <= '0;
        end else if (sample_en && (rdx_q == 3'(gi))) begin
          res_q[gi] <= uo_out_s;
        end
      end
      assign result[8*gi +: 8] = res_q[gi];
    end
  endgenerate

  assign error           = error_q;
  assign pins.tt_ui_in   = tt_ui_in_q;
  assign pins.tt_uio_out = uio_out_c;
  assign pins.tt_uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_mm_host_driver.sv
// ---------------------------------------------------------------------------
// tb_tt_mm_host_driver
// Directed bench for tt_mm_host_driver (default build). A behavioural model
// of the matrix-multiplier project sits on the pin bundle; expected results
// and cycle distances are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_tt_mm_host_driver;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_mat = 32'h0;
  logic [31:0] b_mat = 32'h0;
  logic        busy;
  logic        done;
  logic        error;
  logic [63:0] result;

  tt_mm_host_driver_if pin_if();

  tt_mm_host_driver #(
    .TIMEOUT_CYCLES (1024),
    .SETUP_CYCLES   (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_mat  (a_mat),
    .b_mat  (b_mat),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result),
    .pins   (pin_if)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Matrix-multiplier project model
  // -------------------------------------------------------------------------
  logic [7:0]  m_op [8];
  logic [3:0]  m_wptr = 4'd0;
  logic [3:0]  m_rptr = 4'd0;
  logic [2:0]  m_cd   = 3'd0;
  logic        m_done = 1'b0;
  logic        m_clr  = 1'b1;
  logic        m_hang = 1'b0;
  logic [63:0] m_res;
  logic [7:0]  m_byte;

  always @(posedge clk) begin
    if (m_clr) begin
      m_wptr <= 4'd0;
      m_rptr <= 4'd0;
      m_done <= 1'b0;
      m_cd   <= 3'd0;
    end else begin
      if (pin_if.tt_uio_out[0]) begin
        m_op[m_wptr[2:0]] <= pin_if.tt_ui_in;
        m_wptr <= m_wptr + 4'd1;
        m_done <= 1'b0;
        if (m_wptr == 4'd7) m_cd <= 3'd4;
      end else if (m_cd != 3'd0) begin
        m_cd <= m_cd - 3'd1;
        if ((m_cd == 3'd1) && !m_hang) m_done <= 1'b1;
      end
      if (pin_if.tt_uio_out[2]) m_rptr <= m_rptr + 4'd1;
    end
  end

  always_comb begin
    m_res[15:0]  = 16'(m_op[0]) * 16'(m_op[4]) + 16'(m_op[1]) * 16'(m_op[6]);
    m_res[31:16] = 16'(m_op[0]) * 16'(m_op[5]) + 16'(m_op[1]) * 16'(m_op[7]);
    m_res[47:32] = 16'(m_op[2]) * 16'(m_op[4]) + 16'(m_op[3]) * 16'(m_op[6]);
    m_res[63:48] = 16'(m_op[2]) * 16'(m_op[5]) + 16'(m_op[3]) * 16'(m_op[7]);
    m_byte       = m_res[{m_rptr[2:0], 3'b000} +: 8];
  end

  assign pin_if.tt_uo_out = m_byte;
  assign pin_if.tt_uio_in = {6'b0, m_done, 1'b0};

  // -------------------------------------------------------------------------
  // Pin monitor (samples mid-cycle on the falling edge)
  // -------------------------------------------------------------------------
  int          cyc         = 0;
  int          n_wr        = 0;
  int          n_rd        = 0;
  int          n_done      = 0;
  int          n_viol      = 0;
  int          n_oe_bad    = 0;
  int          start_cyc   = 0;
  int          last_wr_cyc = 0;
  int          last_rd_cyc = 0;
  int          done_cyc    = 0;
  logic        done_err    = 1'b0;
  logic [63:0] done_res    = 64'h0;
  logic        prev_wr     = 1'b0;
  logic        prev_rd     = 1'b0;
  logic [7:0]  prev_ui     = 8'h0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy && !rst) start_cyc <= cyc;
    if (pin_if.tt_uio_out[0]) begin
      n_wr        <= n_wr + 1;
      last_wr_cyc <= cyc;
    end
    if (pin_if.tt_uio_out[2]) begin
      n_rd        <= n_rd + 1;
      last_rd_cyc <= cyc;
    end
    // wr_stb must follow a low cycle with the same byte already on ui_in;
    // rd_stb pulses must be separated; unused uio outputs stay low.
    n_viol <= n_viol
            + int'(pin_if.tt_uio_out[0] && (prev_wr || (pin_if.tt_ui_in != prev_ui)))
            + int'(pin_if.tt_uio_out[2] && prev_rd)
            + int'((pin_if.tt_uio_out & 8'hFA) != 8'h00);
    if (pin_if.tt_uio_oe != 8'h05) n_oe_bad <= n_oe_bad + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
      done_err <= error;
      done_res <= result;
    end
    prev_wr <= pin_if.tt_uio_out[0];
    prev_rd <= pin_if.tt_uio_out[2];
    prev_ui <= pin_if.tt_ui_in;
  end

  // -------------------------------------------------------------------------
  // Checking and stimulus helpers
  // -------------------------------------------------------------------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_clr = 1'b1;
    tick(1);
    m_clr = 1'b0;
  endtask

  task automatic fire(input logic [31:0] a, input logic [31:0] b);
    a_mat = a;
    b_mat = b;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int k;
    base = n_done;
    k    = 0;
    while ((n_done == base) && (k < budget)) begin
      tick(1);
      k++;
    end
    check_eq({tag, ".done_pulse"}, 64'(n_done - base), 64'd1);
  endtask

  localparam logic [63:0] RES_1234 = 64'h0032_002B_0016_0013;
  localparam logic [63:0] RES_FF   = 64'hFC02_FC02_FC02_FC02;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int r0;
    int d0;
    int k;

    // ---------------- reset state ----------------
    tick(3);
    check_eq("rst.busy",    64'(busy),              64'd0);
    check_eq("rst.done",    64'(done),              64'd0);
    check_eq("rst.error",   64'(error),             64'd0);
    check_eq("rst.result",  result,                 64'd0);
    check_eq("rst.ui_in",   64'(pin_if.tt_ui_in),   64'd0);
    check_eq("rst.uio_out", 64'(pin_if.tt_uio_out), 64'd0);
    check_eq("rst.uio_oe",  64'(pin_if.tt_uio_oe),  64'h05);
    rst   = 1'b0;
    m_clr = 1'b0;
    tick(2);

    // ---------------- t1: A=[1,2;3,4] B=[5,6;7,8] ----------------
    w0 = n_wr;
    r0 = n_rd;
    fire(32'h0403_0201, 32'h0807_0605);
    check_eq("t1.busy", 64'(busy), 64'd1);
    wait_done("t1", 200);
    check_eq("t1.result",   result,                         RES_1234);
    check_eq("t1.done_res", done_res,                       RES_1234);
    check_eq("t1.done_err", 64'(done_err),                  64'd0);
    check_eq("t1.n_wr",     64'(n_wr - w0),                 64'd8);
    check_eq("t1.n_rd",     64'(n_rd - r0),                 64'd8);
    check_eq("t1.load_lat", 64'(last_wr_cyc - start_cyc),   64'd16);
    check_eq("t1.read_end", 64'(done_cyc - last_rd_cyc),    64'd2);
    check_eq("t1.idle",     64'(busy),                      64'd0);
    $display("txn t1: result=%h error=%0b wr=%0d rd=%0d", result, error, n_wr - w0, n_rd - r0);
    tick(2);

    // ---------------- t2: all operands 0xFF ----------------
    model_clear();
    fire(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("t2.result_cleared", result, 64'd0);
    wait_done("t2", 200);
    check_eq("t2.result",   result,        RES_FF);
    check_eq("t2.done_err", 64'(done_err), 64'd0);
    $display("txn t2: result=%h error=%0b", result, error);
    tick(2);

    // ---------------- t3: DUT never signals done ----------------
    model_clear();
    m_hang = 1'b1;
    r0     = n_rd;
    fire(32'h0403_0201, 32'h0807_0605);
    wait_done("t3", 1300);
    check_eq("t3.done_err",  64'(done_err),               64'd1);
    check_eq("t3.done_res",  done_res,                    64'd0);
    check_eq("t3.timeout",   64'(done_cyc - last_wr_cyc), 64'd1025);
    check_eq("t3.n_rd",      64'(n_rd - r0),              64'd0);
    tick(3);
    check_eq("t3.err_sticky", 64'(error), 64'd1);
    check_eq("t3.busy",       64'(busy),  64'd0);
    $display("txn t3: result=%h error=%0b wait=%0d", result, error, done_cyc - last_wr_cyc);
    m_hang = 1'b0;

    // ---------------- t4: next start clears error ----------------
    model_clear();
    fire(32'h0403_0201, 32'h0807_0605);
    check_eq("t4.err_clear", 64'(error), 64'd0);
    wait_done("t4", 200);
    check_eq("t4.result",   result,        RES_1234);
    check_eq("t4.done_err", 64'(done_err), 64'd0);
    $display("txn t4: result=%h error=%0b", result, error);
    tick(2);

    // ---------------- t5: second start while busy is ignored ----------------
    model_clear();
    w0 = n_wr;
    r0 = n_rd;
    d0 = n_done;
    fire(32'h0403_0201, 32'h0807_0605);
    tick(4);
    fire(32'h0000_0000, 32'h0000_0000);
    wait_done("t5", 200);
    tick(30);
    check_eq("t5.result", result,            RES_1234);
    check_eq("t5.n_wr",   64'(n_wr - w0),    64'd8);
    check_eq("t5.n_rd",   64'(n_rd - r0),    64'd8);
    check_eq("t5.n_done", 64'(n_done - d0),  64'd1);
    $display("txn t5: result=%h wr=%0d rd=%0d done=%0d", result, n_wr - w0, n_rd - r0, n_done - d0);

    // ---------------- t6: reset during the 5th operand byte ----------------
    model_clear();
    w0 = n_wr;
    d0 = n_done;
    fire(32'h0403_0201, 32'h0807_0605);
    k = 0;
    while (((n_wr - w0) < 4) && (k < 50)) begin
      tick(1);
      k++;
    end
    check_eq("t6.n_wr_before", 64'(n_wr - w0),          64'd4);
    check_eq("t6.ui_b00",      64'(pin_if.tt_ui_in),    64'h05);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6.rst_busy",    64'(busy),               64'd0);
    check_eq("t6.rst_done",    64'(done),               64'd0);
    check_eq("t6.rst_ui_in",   64'(pin_if.tt_ui_in),    64'd0);
    check_eq("t6.rst_uio_out", 64'(pin_if.tt_uio_out),  64'd0);
    tick(2);
    rst = 1'b0;
    tick(20);
    check_eq("t6.no_done",     64'(n_done - d0),        64'd0);
    $display("txn t6: aborted after %0d bytes, done=%0d", n_wr - w0, n_done - d0);
    model_clear();
    fire(32'h0807_0605, 32'h0403_0201);
    wait_done("t6b", 200);
    // A=[5,6;7,8] B=[1,2;3,4] -> c00=23 c01=34 c10=31 c11=46
    check_eq("t6b.result", result, 64'h002E_001F_0022_0017);
    $display("txn t6b: result=%h error=%0b", result, error);
    tick(2);

    // ---------------- pin protocol over the whole run ----------------
    check_eq("pins.strobe_viol", 64'(n_viol),   64'd0);
    check_eq("pins.oe_bad",      64'(n_oe_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
